// File: rtl/life_pkg.sv
// Shared constants and types for the game-of-life cursor logic.
package life_pkg;

  localparam int unsigned GRID_BITS = 4;
  localparam int unsigned NUM_BTN   = 4;

  // Button bit positions on btn_in
  localparam int unsigned BTN_XP  = 0;
  localparam int unsigned BTN_YP  = 1;
  localparam int unsigned BTN_XM  = 2;
  localparam int unsigned BTN_TOG = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/cursor_scheduler_if.sv
// Board RAM toggle handshake between the cursor scheduler and the board memory.
interface cursor_scheduler_if #(
  parameter int unsigned ADDR_W = 2 * life_pkg::GRID_BITS
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, input wr_ack);
  modport slave  (input wr_req, input wr_addr, output wr_ack);

endinterface

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, debounce counter, stable level and
// a registered one-cycle pulse on each rising edge of the stable level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronize, then flip the stable level after a long enough disagreement
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/cursor_scheduler.sv
// Edit cursor owner: debounces the four buttons, queues presses, and serves
// them one per cycle in index order (moves, or a RAM toggle via req/ack).
module cursor_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned GRID_BITS       = life_pkg::GRID_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             btn_in,
  input  logic [3:0]             switch,
  output logic [GRID_BITS-1:0]   pos_x,
  output logic [GRID_BITS-1:0]   pos_y,
  output logic [2*GRID_BITS-1:0] position,
  cursor_scheduler_if.master     ram,
  output logic                   busy,
  output logic                   led
);

  import life_pkg::*;

  localparam int unsigned ADDR_W = 2 * GRID_BITS;

  logic [NUM_BTN-1:0]   rise;
  logic                 edit_en;
  logic                 run_mode;
  logic                 unused_sw;

  sched_state_e         state_q, state_d;
  logic [NUM_BTN-1:0]   pending_q, pending_d;
  logic [GRID_BITS-1:0] pos_x_q, pos_x_d;
  logic [GRID_BITS-1:0] pos_y_q, pos_y_d;
  logic                 wr_req_q, wr_req_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                 busy_q, busy_d;
  logic                 led_q, led_d;

  assign edit_en   = switch[0];
  assign run_mode  = switch[1];
  assign unused_sw = ^switch[3:2];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_in[g]),
      .rise   (rise[g])
    );
  end

  // Queue new presses, serve the lowest pending index, run the write handshake
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | rise;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    busy_d    = 1'b0;
    led_d     = edit_en & ~run_mode;

    case (state_q)
      IDLE: begin
        if (!run_mode && (pending_q != '0)) begin
          if (pending_q[BTN_XP]) begin
            pending_d[BTN_XP] = 1'b0;
            pos_x_d           = pos_x_q + GRID_BITS'(1);
          end else if (pending_q[BTN_YP]) begin
            pending_d[BTN_YP] = 1'b0;
            pos_y_d           = pos_y_q + GRID_BITS'(1);
          end else if (pending_q[BTN_XM]) begin
            pending_d[BTN_XM] = 1'b0;
            pos_x_d           = pos_x_q - GRID_BITS'(1);
          end else begin
            pending_d[BTN_TOG] = 1'b0;
            if (edit_en) begin
              wr_addr_d = {pos_y_q, pos_x_q};
              wr_req_d  = 1'b1;
              state_d   = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (ram.wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Run mode discards everything queued; an in-flight write still finishes
    if (run_mode) begin
      pending_d = '0;
    end

    busy_d = (pending_d != '0) || (state_d == WRITE);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign position    = {pos_y_q, pos_x_q};
  assign ram.wr_req  = wr_req_q;
  assign ram.wr_addr = wr_addr_q;
  assign busy        = busy_q;
  assign led         = led_q;

endmodule

// File: tb/tb_cursor_scheduler.sv
// Bench for cursor_scheduler with a small debounce window and a reference model.
module tb_cursor_scheduler;

  localparam int unsigned DC = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] switch;
  logic [3:0] pos_x, pos_y;
  logic [7:0] position;
  logic       busy, led;

  int checks = 0;
  int errors = 0;

  cursor_scheduler_if #(.ADDR_W(8)) ram_bus ();

  cursor_scheduler #(
    .DEBOUNCE_CYCLES(DC),
    .GRID_BITS      (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_in  (btn_in),
    .switch  (switch),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .position(position),
    .ram     (ram_bus),
    .busy    (busy),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw input history and the architectural state after each edge
  logic [3:0] m_hist [0:DC+1];
  logic [3:0] m_stable, m_rise, m_pending;
  logic       m_write, m_req, m_busy, m_led;
  logic [3:0] m_px, m_py;
  logic [7:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < DC + 2; j++) m_hist[j] = 4'h0;
    m_stable = 0; m_rise = 0; m_pending = 0;
    m_write = 0; m_req = 0; m_busy = 0; m_led = 0;
    m_px = 0; m_py = 0; m_addr = 0;
  endtask

  // Advance the model by one edge using the inputs present at that edge
  task automatic model_step();
    logic [3:0] stable_n, rise_n, pend_n, px_n, py_n;
    logic       write_n, req_n, flip;
    logic [7:0] addr_n;
    int         lo;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int j = DC + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = btn_in;
    // The stable level flips once the last DC synchronized samples all disagree with it
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int j = 2; j < DC + 2; j++) if (m_hist[j][b] == m_stable[b]) flip = 1'b0;
      stable_n[b] = flip ? ~m_stable[b] : m_stable[b];
    end
    rise_n  = stable_n & ~m_stable;
    pend_n  = m_pending | m_rise;
    px_n    = m_px; py_n = m_py; write_n = m_write; req_n = m_req; addr_n = m_addr;
    if (m_write) begin
      if (ram_bus.wr_ack) begin write_n = 0; req_n = 0; end
    end else if (!switch[1] && m_pending != 0) begin
      lo = 0;
      while (!m_pending[lo]) lo++;
      pend_n[lo] = 1'b0;
      case (lo)
        0: px_n = (m_px + 1) % 16;
        1: py_n = (m_py + 1) % 16;
        2: px_n = (m_px + 15) % 16;
        default: if (switch[0]) begin
          addr_n = m_py * 16 + m_px; req_n = 1; write_n = 1;
        end
      endcase
    end
    if (switch[1]) pend_n = 0;
    m_stable = stable_n; m_rise = rise_n; m_pending = pend_n;
    m_px = px_n; m_py = py_n; m_write = write_n; m_req = req_n; m_addr = addr_n;
    m_busy = (pend_n != 0) || write_n;
    m_led  = switch[0] & ~switch[1];
  endtask

  // One clock edge, then compare every output against the model
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    chk("pos_x", 32'(pos_x), 32'(m_px));
    chk("pos_y", 32'(pos_y), 32'(m_py));
    chk("position", 32'(position), 32'({m_py, m_px}));
    chk("wr_req", 32'(ram_bus.wr_req), 32'(m_req));
    chk("wr_addr", 32'(ram_bus.wr_addr), 32'(m_addr));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("led", 32'(led), 32'(m_led));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press(input logic [3:0] mask);
    btn_in = mask;
    run(10);
    btn_in = 4'h0;
    run(10);
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (ram_bus.wr_req !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk(name, 32'(ram_bus.wr_req), 32'd1);
  endtask

  int busy_cnt;
  int req_cnt;

  initial begin
    model_reset();
    rst_n = 1'b0; btn_in = 4'h0; switch = 4'h0; ram_bus.wr_ack = 1'b0;
    run(2);
    rst_n = 1'b1;
    chk("rst_pos_x", 32'(pos_x), 32'd0);
    chk("rst_wr_req", 32'(ram_bus.wr_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single x+ press: exact latency, then a second press
    btn_in = 4'b0001;
    run(7);
    chk("lat_before", 32'(pos_x), 32'd0);
    cycle();
    chk("lat_at8", 32'(pos_x), 32'd1);
    chk("lat_position", 32'(position), 32'h01);
    chk("model_px_pin", 32'(m_px), 32'd1);
    run(12);
    btn_in = 4'h0;
    run(12);
    press(4'b0001);
    chk("second_press", 32'(pos_x), 32'd2);

    // x- down through zero, then sixteen y+ presses wrap
    press(4'b0100);
    press(4'b0100);
    chk("xm_to_0", 32'(pos_x), 32'd0);
    press(4'b0100);
    chk("xm_wrap", 32'(pos_x), 32'd15);
    chk("xm_position", 32'(position), 32'h0F);
    press(4'b0010);
    chk("yp_first", 32'(pos_y), 32'd1);
    for (int i = 0; i < 15; i++) press(4'b0010);
    chk("yp_wrap", 32'(pos_y), 32'd0);

    // Simultaneous x+ and y+ from the origin
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    busy_cnt = 0;
    btn_in = 4'b0011;
    for (int i = 0; i < 20; i++) begin cycle(); if (busy) busy_cnt++; end
    btn_in = 4'h0;
    for (int i = 0; i < 12; i++) begin cycle(); if (busy) busy_cnt++; end
    chk("dual_position", 32'(position), 32'h11);
    chk("dual_busy_cycles", 32'(busy_cnt), 32'd2);

    // Short glitches are filtered out
    busy_cnt = 0;
    for (int r = 0; r < 5; r++) begin
      btn_in = 4'b0001;
      for (int i = 0; i < 2; i++) begin cycle(); if (busy) busy_cnt++; end
      btn_in = 4'h0;
      for (int i = 0; i < 3; i++) begin cycle(); if (busy) busy_cnt++; end
    end
    run(8);
    chk("glitch_pos_x", 32'(pos_x), 32'd1);
    chk("glitch_busy", 32'(busy_cnt), 32'd0);

    // Move to (3,2), then toggle with a slow ack and an x+ press during the stall
    press(4'b0001);
    press(4'b0001);
    press(4'b0010);
    chk("at_3_2", 32'(position), 32'h23);
    switch = 4'b0001;
    cycle();
    chk("led_edit", 32'(led), 32'd1);
    btn_in = 4'b1000;
    run(2);
    btn_in = 4'b1001;
    wait_req("tog_req_seen");
    chk("tog_addr", 32'(ram_bus.wr_addr), 32'h23);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_req", 32'(ram_bus.wr_req), 32'd1);
      chk("stall_addr", 32'(ram_bus.wr_addr), 32'h23);
      chk("stall_pos_x", 32'(pos_x), 32'd3);
    end
    ram_bus.wr_ack = 1'b1;
    cycle();
    ram_bus.wr_ack = 1'b0;
    chk("ack_req_low", 32'(ram_bus.wr_req), 32'd0);
    chk("ack_pos_x", 32'(pos_x), 32'd3);
    cycle();
    chk("post_write_pos_x", 32'(pos_x), 32'd4);
    btn_in = 4'h0;
    run(10);

    // Run mode discards all presses
    switch = 4'b0011;
    cycle();
    chk("led_run", 32'(led), 32'd0);
    req_cnt = 0;
    btn_in = 4'b1111;
    for (int i = 0; i < 12; i++) begin cycle(); if (ram_bus.wr_req) req_cnt++; end
    btn_in = 4'h0;
    for (int i = 0; i < 12; i++) begin cycle(); if (ram_bus.wr_req) req_cnt++; end
    chk("run_no_req", 32'(req_cnt), 32'd0);
    chk("run_position", 32'(position), 32'h24);

    // Reset in the middle of a write
    switch = 4'b0001;
    btn_in = 4'b1000;
    wait_req("rst_write_req");
    btn_in = 4'h0;
    run(2);
    rst_n = 1'b0;
    cycle();
    chk("midwrite_req", 32'(ram_bus.wr_req), 32'd0);
    chk("midwrite_pos", 32'(position), 32'h00);
    chk("midwrite_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
